// File: rtl/rs_bank_if.sv
// rs_bank_if: bundles the issue, CDB, dispatch and occupancy signals of one
// reservation-station bank.
//   master : issue stage / CDB / functional unit side (drives requests)
//   slave  : the bank itself (drives issue_ready/tag, disp_*, count, empty)
interface rs_bank_if #(
    parameter int ENTRIES = 3,
    parameter int DATA_W  = 9,
    parameter int OP_W    = 3,
    parameter int REG_W   = 3,
    parameter int TAG_W   = 4
);
    localparam int CNT_W = $clog2(ENTRIES + 1);

    logic              flush;
    logic              issue_valid;
    logic              issue_ready;
    logic [OP_W-1:0]   issue_op;
    logic [REG_W-1:0]  issue_dest;
    logic              issue_j_rdy;
    logic              issue_k_rdy;
    logic [DATA_W-1:0] issue_vj;
    logic [DATA_W-1:0] issue_vk;
    logic [TAG_W-1:0]  issue_qj;
    logic [TAG_W-1:0]  issue_qk;
    logic [TAG_W-1:0]  issue_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              disp_valid;
    logic              disp_ready;
    logic [OP_W-1:0]   disp_op;
    logic [REG_W-1:0]  disp_dest;
    logic [DATA_W-1:0] disp_a;
    logic [DATA_W-1:0] disp_b;
    logic [TAG_W-1:0]  disp_tag;
    logic [CNT_W-1:0]  count;
    logic              empty;

    modport master (
        output flush, issue_valid, issue_op, issue_dest, issue_j_rdy, issue_k_rdy,
               issue_vj, issue_vk, issue_qj, issue_qk, cdb_valid, cdb_tag, cdb_data,
               disp_ready,
        input  issue_ready, issue_tag, disp_valid, disp_op, disp_dest, disp_a, disp_b,
               disp_tag, count, empty
    );

    modport slave (
        input  flush, issue_valid, issue_op, issue_dest, issue_j_rdy, issue_k_rdy,
               issue_vj, issue_vk, issue_qj, issue_qk, cdb_valid, cdb_tag, cdb_data,
               disp_ready,
        output issue_ready, issue_tag, disp_valid, disp_op, disp_dest, disp_a, disp_b,
               disp_tag, count, empty
    );
endinterface

// File: rtl/rs_bank.sv
// rs_bank: reservation-station bank for one functional-unit class.
// Accepts renamed instructions, snoops the CDB for pending operands,
// dispatches the oldest ready entry (lowest rank) to the FU and frees an
// entry when its own tag is broadcast after it was dispatched.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - rs_bank_if slave: flush, issue_*, cdb_*, disp_*, count, empty
module rs_bank #(
    parameter int ENTRIES  = 3,
    parameter int DATA_W   = 9,
    parameter int OP_W     = 3,
    parameter int REG_W    = 3,
    parameter int TAG_W    = 4,
    parameter int BASE_TAG = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    rs_bank_if.slave bus
);
    localparam int CNT_W = $clog2(ENTRIES + 1);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic              r_busy  [ENTRIES];
    logic              r_sent  [ENTRIES];
    logic [OP_W-1:0]   r_op    [ENTRIES];
    logic [REG_W-1:0]  r_dest  [ENTRIES];
    logic              r_j_rdy [ENTRIES];
    logic              r_k_rdy [ENTRIES];
    logic [DATA_W-1:0] r_vj    [ENTRIES];
    logic [DATA_W-1:0] r_vk    [ENTRIES];
    logic [TAG_W-1:0]  r_qj    [ENTRIES];
    logic [TAG_W-1:0]  r_qk    [ENTRIES];
    logic [IDX_W-1:0]  r_rank  [ENTRIES];
    logic [CNT_W-1:0]  r_count;

    logic [ENTRIES-1:0] w_free_vec;
    logic               w_free;
    logic [IDX_W-1:0]   w_free_rank;
    logic               w_found;
    logic [IDX_W-1:0]   w_issue_idx;
    logic               w_issue_ready;
    logic               w_do_issue;
    logic               w_byp_j;
    logic               w_byp_k;
    logic [IDX_W-1:0]   w_new_rank;
    logic               w_disp_valid;
    logic [IDX_W-1:0]   w_sel;
    logic [IDX_W-1:0]   w_best_rank;
    logic               w_disp_fire;

    function automatic logic [TAG_W-1:0] tag_of(input logic [IDX_W-1:0] idx);
        return TAG_W'(BASE_TAG) + TAG_W'(idx);
    endfunction

    always_comb begin
        // Only a dispatched entry may be freed by its own tag; tags are unique
        // so at most one entry matches.
        w_free_vec  = '0;
        w_free_rank = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (bus.cdb_valid && r_busy[i] && r_sent[i] &&
                bus.cdb_tag == tag_of(IDX_W'(i))) begin
                w_free_vec[i] = 1'b1;
                w_free_rank   = r_rank[i];
            end
        end
        w_free = |w_free_vec;

        // Lowest non-busy slot; an entry freed this cycle is still busy here,
        // so it is never reused in the same cycle.
        w_found     = 1'b0;
        w_issue_idx = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!r_busy[i] && !w_found) begin
                w_found     = 1'b1;
                w_issue_idx = IDX_W'(i);
            end
        end

        w_issue_ready = (r_count < CNT_W'(ENTRIES));
        w_do_issue    = bus.issue_valid && w_issue_ready && !bus.flush;
        w_byp_j       = !bus.issue_j_rdy && bus.cdb_valid && (bus.cdb_tag == bus.issue_qj);
        w_byp_k       = !bus.issue_k_rdy && bus.cdb_valid && (bus.cdb_tag == bus.issue_qk);
        // The new entry is youngest: rank equals the post-free occupancy.
        w_new_rank    = IDX_W'(r_count) - IDX_W'(w_free);

        w_disp_valid = 1'b0;
        w_sel        = '0;
        w_best_rank  = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (r_busy[i] && !r_sent[i] && r_j_rdy[i] && r_k_rdy[i] &&
                (!w_disp_valid || r_rank[i] < w_best_rank)) begin
                w_disp_valid = 1'b1;
                w_sel        = IDX_W'(i);
                w_best_rank  = r_rank[i];
            end
        end
        w_disp_fire = w_disp_valid && bus.disp_ready;

        bus.issue_ready = w_issue_ready;
        bus.issue_tag   = tag_of(w_issue_idx);
        bus.disp_valid  = w_disp_valid;
        bus.disp_op     = w_disp_valid ? r_op[w_sel]   : '0;
        bus.disp_dest   = w_disp_valid ? r_dest[w_sel] : '0;
        bus.disp_a      = w_disp_valid ? r_vj[w_sel]   : '0;
        bus.disp_b      = w_disp_valid ? r_vk[w_sel]   : '0;
        bus.disp_tag    = w_disp_valid ? tag_of(w_sel) : '0;
        bus.count       = r_count;
        bus.empty       = (r_count == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_busy[i]  <= 1'b0;
                r_sent[i]  <= 1'b0;
                r_op[i]    <= '0;
                r_dest[i]  <= '0;
                r_j_rdy[i] <= 1'b0;
                r_k_rdy[i] <= 1'b0;
                r_vj[i]    <= '0;
                r_vk[i]    <= '0;
                r_qj[i]    <= '0;
                r_qk[i]    <= '0;
                r_rank[i]  <= '0;
            end
        end else if (bus.flush) begin
            r_count <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_busy[i] <= 1'b0;
                r_sent[i] <= 1'b0;
            end
        end else begin
            r_count <= r_count + CNT_W'(w_do_issue) - CNT_W'(w_free);
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (r_busy[i] && !r_j_rdy[i] && bus.cdb_valid && bus.cdb_tag == r_qj[i]) begin
                    r_vj[i]    <= bus.cdb_data;
                    r_j_rdy[i] <= 1'b1;
                end
                if (r_busy[i] && !r_k_rdy[i] && bus.cdb_valid && bus.cdb_tag == r_qk[i]) begin
                    r_vk[i]    <= bus.cdb_data;
                    r_k_rdy[i] <= 1'b1;
                end
                if (w_disp_fire && w_sel == IDX_W'(i)) begin
                    r_sent[i] <= 1'b1;
                end
                if (w_free_vec[i]) begin
                    r_busy[i] <= 1'b0;
                    r_sent[i] <= 1'b0;
                end else if (r_busy[i] && w_free && r_rank[i] > w_free_rank) begin
                    r_rank[i] <= r_rank[i] - IDX_W'(1);
                end
                if (w_do_issue && w_issue_idx == IDX_W'(i)) begin
                    r_busy[i]  <= 1'b1;
                    r_sent[i]  <= 1'b0;
                    r_op[i]    <= bus.issue_op;
                    r_dest[i]  <= bus.issue_dest;
                    r_j_rdy[i] <= bus.issue_j_rdy | w_byp_j;
                    r_k_rdy[i] <= bus.issue_k_rdy | w_byp_k;
                    r_vj[i]    <= w_byp_j ? bus.cdb_data : bus.issue_vj;
                    r_vk[i]    <= w_byp_k ? bus.cdb_data : bus.issue_vk;
                    r_qj[i]    <= bus.issue_qj;
                    r_qk[i]    <= bus.issue_qk;
                    r_rank[i]  <= w_new_rank;
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_bank.sv
// tb_rs_bank: drives rs_bank with directed scenarios and random traffic and
// checks it against an age-queue model of the station.
module tb_rs_bank;
    localparam int E  = 3;
    localparam int DW = 9;
    localparam int OW = 3;
    localparam int RW = 3;
    localparam int TW = 4;
    localparam int BT = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rs_bank_if #(.ENTRIES(E), .DATA_W(DW), .OP_W(OW), .REG_W(RW), .TAG_W(TW)) bus ();

    rs_bank #(.ENTRIES(E), .DATA_W(DW), .OP_W(OW), .REG_W(RW), .TAG_W(TW), .BASE_TAG(BT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    // Model: per-slot contents plus a queue of slot indices, oldest first.
    bit            m_busy [E];
    bit            m_sent [E];
    bit            m_jr   [E];
    bit            m_kr   [E];
    logic [OW-1:0] m_op   [E];
    logic [RW-1:0] m_dest [E];
    logic [DW-1:0] m_vj   [E];
    logic [DW-1:0] m_vk   [E];
    logic [TW-1:0] m_qj   [E];
    logic [TW-1:0] m_qk   [E];
    int            m_age  [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_free_slot();
        for (int i = 0; i < E; i++) if (!m_busy[i]) return i;
        return 0;
    endfunction

    function automatic int m_winner();
        foreach (m_age[k]) begin
            int s;
            s = m_age[k];
            if (!m_sent[s] && m_jr[s] && m_kr[s]) return s;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < E; i++) begin
            m_busy[i] = 1'b0;
            m_sent[i] = 1'b0;
        end
        m_age.delete();
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_clear();
        end else if (bus.flush) begin
            model_clear();
        end else begin
            int w;
            int f;
            int s;
            bit acc;
            w = m_winner();
            f = -1;
            if (bus.cdb_valid)
                for (int i = 0; i < E; i++)
                    if (m_busy[i] && m_sent[i] && int'(bus.cdb_tag) == BT + i) f = i;
            acc = bus.issue_valid && (m_age.size() < E);
            s = m_free_slot();
            if (bus.cdb_valid) begin
                for (int i = 0; i < E; i++) begin
                    if (m_busy[i] && !m_jr[i] && m_qj[i] == bus.cdb_tag) begin
                        m_jr[i] = 1'b1; m_vj[i] = bus.cdb_data;
                    end
                    if (m_busy[i] && !m_kr[i] && m_qk[i] == bus.cdb_tag) begin
                        m_kr[i] = 1'b1; m_vk[i] = bus.cdb_data;
                    end
                end
            end
            if (w >= 0 && bus.disp_ready) m_sent[w] = 1'b1;
            if (f >= 0) begin
                m_busy[f] = 1'b0;
                m_sent[f] = 1'b0;
                foreach (m_age[k]) if (m_age[k] == f) begin m_age.delete(k); break; end
            end
            if (acc) begin
                bit bj;
                bit bk;
                bj = !bus.issue_j_rdy && bus.cdb_valid && bus.cdb_tag == bus.issue_qj;
                bk = !bus.issue_k_rdy && bus.cdb_valid && bus.cdb_tag == bus.issue_qk;
                m_busy[s] = 1'b1;
                m_sent[s] = 1'b0;
                m_op[s]   = bus.issue_op;
                m_dest[s] = bus.issue_dest;
                m_jr[s]   = bus.issue_j_rdy || bj;
                m_kr[s]   = bus.issue_k_rdy || bk;
                m_vj[s]   = bj ? bus.cdb_data : bus.issue_vj;
                m_vk[s]   = bk ? bus.cdb_data : bus.issue_vk;
                m_qj[s]   = bus.issue_qj;
                m_qk[s]   = bus.issue_qk;
                m_age.push_back(s);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            int w;
            w = m_winner();
            chk("issue_ready", bus.issue_ready, m_age.size() < E);
            if (m_age.size() < E) chk("issue_tag", bus.issue_tag, BT + m_free_slot());
            chk("count", bus.count, m_age.size());
            chk("empty", bus.empty, m_age.size() == 0);
            chk("disp_valid", bus.disp_valid, w >= 0);
            if (w >= 0) begin
                chk("disp_tag", bus.disp_tag, BT + w);
                chk("disp_op", bus.disp_op, m_op[w]);
                chk("disp_dest", bus.disp_dest, m_dest[w]);
                chk("disp_a", bus.disp_a, m_vj[w]);
                chk("disp_b", bus.disp_b, m_vk[w]);
            end
        end
    end

    task automatic idle();
        bus.flush = 0; bus.issue_valid = 0; bus.issue_op = '0; bus.issue_dest = '0;
        bus.issue_j_rdy = 0; bus.issue_k_rdy = 0; bus.issue_vj = '0; bus.issue_vk = '0;
        bus.issue_qj = '0; bus.issue_qk = '0; bus.cdb_valid = 0; bus.cdb_tag = '0;
        bus.cdb_data = '0; bus.disp_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.issue_valid = 0;
        bus.cdb_valid = 0;
        bus.flush = 0;
    endtask

    task automatic iss(input int op, input int dest, input bit jr, input int vj, input int qj,
                       input bit kr, input int vk, input int qk);
        bus.issue_valid = 1;
        bus.issue_op = OW'(op);
        bus.issue_dest = RW'(dest);
        bus.issue_j_rdy = jr;
        bus.issue_vj = DW'(vj);
        bus.issue_qj = TW'(qj);
        bus.issue_k_rdy = kr;
        bus.issue_vk = DW'(vk);
        bus.issue_qk = TW'(qk);
    endtask

    task automatic cdb(input int tag, input int data);
        bus.cdb_valid = 1;
        bus.cdb_tag = TW'(tag);
        bus.cdb_data = DW'(data);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_issue_ready", bus.issue_ready, 1);
        chk("rst_disp_valid", bus.disp_valid, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_issue_tag", bus.issue_tag, BT);
        chk("rst_disp_a", bus.disp_a, 0);
        chk("rst_disp_tag", bus.disp_tag, 0);
        rst_n = 1;
        cmp_en = 1;

        // add then sub, both ready
        iss(0, 1, 1, 5, 0, 1, 3, 0); #1;
        chk("t1_tag0", bus.issue_tag, 0);
        tick();
        iss(1, 2, 1, 9, 0, 1, 1, 0); bus.disp_ready = 1; #1;
        chk("t1_tag1", bus.issue_tag, 1);
        chk("t1_dv", bus.disp_valid, 1);
        chk("t1_dtag_add", bus.disp_tag, 0);
        chk("t1_a_add", bus.disp_a, 5);
        chk("t1_b_add", bus.disp_b, 3);
        chk("t1_op_add", bus.disp_op, 0);
        tick(); #1;
        chk("t1_dtag_sub", bus.disp_tag, 1);
        chk("t1_a_sub", bus.disp_a, 9);
        chk("t1_op_sub", bus.disp_op, 1);
        chk("t1_count2", bus.count, 2);
        tick(); #1;
        chk("t1_dv_none", bus.disp_valid, 0);
        chk("t1_count_held", bus.count, 2);
        cdb(0, 8); tick(); #1;
        chk("t1_count1", bus.count, 1);
        cdb(1, 10); tick(); #1;
        chk("t1_empty", bus.empty, 1);

        // fill, full stall, free tag 1 and reuse it
        for (int n = 0; n < 3; n++) begin
            iss(2, n, 1, n + 1, 0, 1, 2, 0); #1;
            chk("t2_tag", bus.issue_tag, n);
            tick();
        end
        #1;
        chk("t2_count3", bus.count, 3);
        iss(2, 7, 1, 1, 0, 1, 1, 0); #1;
        chk("t2_full", bus.issue_ready, 0);
        tick();
        cdb(1, 0); #1;
        chk("t2_full_free", bus.issue_ready, 0);
        tick(); #1;
        chk("t2_count2", bus.count, 2);
        chk("t2_reuse_tag", bus.issue_tag, 1);
        iss(3, 4, 1, 11, 0, 1, 12, 0); tick(); #1;
        chk("t2_count3b", bus.count, 3);
        chk("t2_disp_new", bus.disp_tag, 1);
        cdb(0, 0); tick();
        cdb(2, 0); tick();
        cdb(1, 0); tick(); #1;
        chk("t2_empty", bus.empty, 1);

        // issue bypass and snoop of the same outside tag
        bus.disp_ready = 0;
        iss(0, 4, 0, 0, 5, 1, 2, 0); tick();
        iss(1, 5, 0, 0, 5, 1, 7, 0); cdb(5, 9'h1FF); #1;
        chk("t3_tag1", bus.issue_tag, 1);
        chk("t3_wake_cycle", bus.disp_valid, 0);
        tick(); #1;
        chk("t3_dv", bus.disp_valid, 1);
        chk("t3_dtag", bus.disp_tag, 0);
        chk("t3_a", bus.disp_a, 9'h1FF);
        chk("t3_b", bus.disp_b, 2);
        bus.disp_ready = 1;
        tick(); #1;
        chk("t3_dtag_byp", bus.disp_tag, 1);
        chk("t3_a_byp", bus.disp_a, 9'h1FF);
        chk("t3_b_byp", bus.disp_b, 7);
        tick();
        cdb(0, 0); tick();
        cdb(1, 0); tick(); #1;
        chk("t3_empty", bus.empty, 1);

        // age order: oldest waits, younger goes, oldest wins after wake
        iss(2, 1, 0, 0, 6, 1, 1, 0); tick();
        iss(0, 2, 1, 16, 0, 1, 32, 0); tick(); #1;
        chk("t4_young", bus.disp_tag, 1);
        tick();
        bus.disp_ready = 0;
        iss(3, 3, 1, 51, 0, 1, 68, 0); tick(); #1;
        chk("t4_c", bus.disp_tag, 2);
        chk("t4_c_a", bus.disp_a, 51);
        tick(); #1;
        chk("t4_stall", bus.disp_tag, 2);
        chk("t4_stall_a", bus.disp_a, 51);
        cdb(6, 9'h0AA); #1;
        chk("t4_wake_cycle", bus.disp_tag, 2);
        tick(); #1;
        chk("t4_old_wins", bus.disp_tag, 0);
        chk("t4_old_a", bus.disp_a, 9'h0AA);
        chk("t4_old_b", bus.disp_b, 1);
        bus.disp_ready = 1;
        tick(); #1;
        chk("t4_then_c", bus.disp_tag, 2);
        tick();

        // flush beats issue and free
        cdb(0, 0); tick(); #1;
        chk("t5_count2", bus.count, 2);
        bus.flush = 1; cdb(1, 0); iss(1, 1, 1, 1, 0, 1, 1, 0); #1;
        chk("t5_ready_flush", bus.issue_ready, 1);
        tick(); #1;
        chk("t5_count0", bus.count, 0);
        chk("t5_empty", bus.empty, 1);
        chk("t5_dv", bus.disp_valid, 0);

        // asynchronous reset with two busy entries
        bus.disp_ready = 0;
        iss(0, 1, 1, 1, 0, 1, 1, 0); tick();
        iss(0, 2, 1, 2, 0, 1, 2, 0); tick(); #1;
        chk("t6_count2", bus.count, 2);
        rst_n = 0; #1;
        chk("t6_count0", bus.count, 0);
        chk("t6_dv", bus.disp_valid, 0);
        chk("t6_ready", bus.issue_ready, 1);
        @(posedge clk); #1;
        rst_n = 1;

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            bus.issue_valid = ($urandom_range(0, 2) != 0);
            bus.issue_op = OW'($urandom_range(0, 3));
            bus.issue_dest = RW'($urandom);
            bus.issue_j_rdy = $urandom_range(0, 1);
            bus.issue_k_rdy = $urandom_range(0, 1);
            bus.issue_vj = ($urandom_range(0, 7) == 0) ? '1 : DW'($urandom);
            bus.issue_vk = ($urandom_range(0, 7) == 0) ? '1 : DW'($urandom);
            bus.issue_qj = TW'($urandom_range(0, 7));
            bus.issue_qk = TW'($urandom_range(0, 7));
            bus.cdb_valid = $urandom_range(0, 1);
            bus.cdb_tag = TW'($urandom_range(0, 7));
            bus.cdb_data = ($urandom_range(0, 7) == 0) ? '1 : DW'($urandom);
            bus.disp_ready = ($urandom_range(0, 2) != 0);
            bus.flush = ($urandom_range(0, 63) == 0);
            @(posedge clk); #1;
        end
        idle();
        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rs_bank.md
# rs_bank

Parametrised reservation-station bank for the Tomasulo core: one instance per functional-unit class (add/sub, mul/div, ...), each with its own tag range on the shared common data bus (CDB). It accepts renamed instructions from the issue stage, snoops the CDB for pending operands, dispatches the oldest ready entry to its functional unit through a valid/ready handshake, and frees an entry when its own result appears on the CDB. Per-operand ready bits replace all-ones sentinel values, so every data value, including all-ones, is legal.

## Interface
- ENTRIES, 3: number of station entries (1..8)
- DATA_W, 9: operand/result width
- OP_W, 3: opcode width (000 add, 001 sub, 010 mul, 011 div)
- REG_W, 3: architectural destination register index width
- TAG_W, 4: CDB tag width; must hold BASE_TAG+ENTRIES-1
- BASE_TAG, 0: tag of entry 0; entry i owns tag BASE_TAG+i

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all entries
- issue_valid  in  1  issue stage offers an instruction
- issue_ready  out  1  bank can accept (count < ENTRIES)
- issue_op  in  OP_W  opcode
- issue_dest  in  REG_W  destination register
- issue_j_rdy, issue_k_rdy  in  1  operand value is valid (else wait on tag)
- issue_vj, issue_vk  in  DATA_W  operand values
- issue_qj, issue_qk  in  TAG_W  producer tags when not ready
- issue_tag  out  TAG_W  tag the accepted instruction receives (for register-file rename)
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_W  producer tag
- cdb_data  in  DATA_W  result
- disp_valid  out  1  an entry is ready for the FU
- disp_ready  in  1  FU accepts
- disp_op  out  OP_W; disp_dest  out  REG_W; disp_a, disp_b  out  DATA_W; disp_tag  out  TAG_W
- count  out  clog2(ENTRIES+1)  busy entries
- empty  out  1  count == 0

## Operation
- Entry state: busy, sent, op, dest, j_rdy/vj/qj, k_rdy/vk/qk, rank (age; 0 = oldest).
- Issue: on issue_valid && issue_ready, the lowest-index non-busy entry is written, and its rank is set to the current count; issue_tag = BASE_TAG + that index, combinational and valid whenever issue_ready is high.
- Issue bypass: if an operand is not ready and cdb_valid && cdb_tag == issue_q* in the same cycle, the entry captures cdb_data with rdy = 1.
- Snoop: every busy entry with a non-ready operand whose q matches a valid cdb_tag captures cdb_data and sets rdy.
- Dispatch select: candidates are busy && !sent && j_rdy && k_rdy entries. Lowest rank wins. disp_* fields come from the winner and are combinational from registered state. On disp_valid && disp_ready, the winner's sent bit is set.
- Free: cdb_valid && cdb_tag == own tag && busy && sent clears busy. All entries with a greater rank decrement their rank. If the entry is not sent, the match is ignored.
- Simultaneous issue and free: the new entry's rank is count minus one if a free occurs. An entry freed in this cycle is not reused in the same cycle. count is unchanged.
- flush: clears all busy/sent bits and dominates issue, snoop and free.
- The CDB tag space is shared; tags outside [BASE_TAG, BASE_TAG+ENTRIES-1] only wake operands.

## Timing
- Reset (rst_n low, async): all busy/sent = 0. Outputs: issue_ready = 1, disp_valid = 0, count = 0, empty = 1, issue_tag = BASE_TAG, disp_* = 0.
- An instruction issued with both operands ready at edge t can dispatch in cycle t+1 (one cycle latency).
- A CDB wake at edge t makes the entry eligible from cycle t+1. A woken entry never dispatches in the wake cycle.
- disp_valid does not depend on disp_ready. The selection is held stable while it is stalled unless an older entry becomes ready.
- issue_ready does not depend on issue_valid, flush or same-cycle free. When count = ENTRIES, issue_ready = 0 even if an entry frees this cycle.
- Ranks stay a permutation of 0..count-1 at all times.

## Test plan
- Reset mid-operation with 2 busy entries: rst_n pulse low -> count = 0, disp_valid = 0, issue_ready = 1, asynchronously.
- Issue add(vj=5, vk=3, ready) then sub(vj=9, vk=1) into an empty bank -> tags BASE_TAG, BASE_TAG+1. Dispatch order: add first (cycle t+1), then sub. count = 2 until CDB tags 0 and 1 return.
- Fill the bank (ENTRIES = 3) -> issue_ready = 0 on the fourth attempt. CDB frees tag 1 -> the next issue receives tag 1 and rank 2.
- Entry waiting on tag 5 and a same-cycle issue with qj = 5 while cdb(5, 0x1FF) -> both capture 0x1FF. The waiting entry dispatches the next cycle with disp_a = 0x1FF.
- Oldest not ready, younger ready -> the younger dispatches. When the oldest wakes, it wins over any later-issued ready entry. disp_ready held low -> disp_* stable.
- flush asserted together with issue_valid and a cdb free -> all entries cleared, no entry written, count = 0 the next cycle.
